// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory controller. Handles byte, halfword and word
// loads and stores. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
//
// Configuration macro: DMC_HALFWORD_EN. Define it to enable halfword accesses (size=01).
// When it is undefined, every halfword request is rejected with err.
//
// Parameters:
//   ADDR_W  word-address width; the memory holds 2^ADDR_W 32-bit words
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory contents are kept)
//   req    request valid; sampled only while idle
//   we     1 = store, 0 = load
//   size   00 = byte, 01 = halfword, 10 = word, 11 = reserved
//   uns    1 = zero-extend sub-word load, 0 = sign-extend
//   addr   byte address; bits above ADDR_W+1 are ignored (wrap-around)
//   wdata  right-aligned store data
//   busy   high whenever the controller is not idle
//   done   one-cycle completion pulse
//   err    valid with done: the access was rejected
//   rdata  last successful load result, valid with done for loads
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e            state_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              err_q;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic        bad_req;
  logic [31:0] mem_rd;
  logic [31:0] wr_word;

  // Upper address bits only select wrap-around aliases.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  // Extract the addressed lane from a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SzByte:  return {{24{~u & b[7]}}, b};
      SzHalf:  return {{16{~u & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed lane(s) of the old word with the low bits of the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] w;
    w = old;
    if (sz == SzHalf) begin
      if (lane[1]) w[31:16] = wd[15:0];
      else         w[15:0]  = wd[15:0];
    end else begin
      w[{lane, 3'b000} +: 8] = wd[7:0];
    end
    return w;
  endfunction

  // Reject misaligned accesses, reserved sizes and (when disabled) all halfwords.
  always_comb begin
    bad_req = 1'b0;
    case (size)
      SzByte: bad_req = 1'b0;
`ifdef DMC_HALFWORD_EN
      SzHalf: bad_req = addr[0];
`else
      SzHalf: bad_req = 1'b1;
`endif
      SzWord: bad_req = (addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  assign mem_rd  = mem[addr_q[ADDR_W+1:2]];
  assign wr_word = (size_q == SzWord) ? wdata_q : store_merge(old_q, wdata_q, addr_q[1:0], size_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            uns_q   <= uns;
            size_q  <= size;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            if (bad_req) begin
              state_q <= StResp;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (we && (size == SzWord)) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (we_q) begin
            // Sub-word store: capture the old word for the merge.
            old_q   <= mem_rd;
            state_q <= StWrite;
          end else begin
            rdata_q <= load_extract(mem_rd, addr_q[1:0], size_q, uns_q);
            state_q <= StResp;
            done_q  <= 1'b1;
          end
        end
        StWrite: begin
          state_q <= StResp;
          done_q  <= 1'b1;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory is not reset; an async reset moves the FSM out of StWrite before the next
  // edge, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == StWrite) begin
      mem[addr_q[ADDR_W+1:2]] <= wr_word;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat;
  logic        e;
  logic [31:0] rd;

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .size  (size),
    .uns   (uns),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  // Stimulus only: present one request while idle, then wait (bounded) for done.
  // lat = number of cycles from the accepting edge to the done cycle (99 = timeout).
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int l, output logic er, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    l = 99; er = 1'bx; r = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        l = i; er = err; r = rdata;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_word;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, lat, e, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wst_lat: got %0d want 2", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wst_err: got %b want 0", e); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wld_lat: got %0d want 2", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wld_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wld_data: got %h want 12345678", rd); end
  endtask

  task automatic test_byte;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, lat, e, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bst_lat: got %0d want 3", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL bst_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL bst_rdata_kept: got %h want 12345678", rd); end
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFAB) begin n_bad++; $display("FAIL bld_s11: got %h want ffffffab", rd); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_bad++; $display("FAIL merge_w10: got %h want 1234ab78", rd); end
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h0000_00AB) begin n_bad++; $display("FAIL bld_u11: got %h want 000000ab", rd); end
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h0000_0012) begin n_bad++; $display("FAIL bld_s13: got %h want 00000012", rd); end
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h8000_7F01, lat, e, rd);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL bld_s23: got %h want ffffff80", rd); end
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL bld_s20: got %h want 00000001", rd); end
  endtask

  task automatic test_half;
`ifdef DMC_HALFWORD_EN
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL hld_s12: got %h want 00001234", rd); end
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'hFFFF_8000) begin n_bad++; $display("FAIL hld_s22: got %h want ffff8000", rd); end
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h0000_8000) begin n_bad++; $display("FAIL hld_u22: got %h want 00008000", rd); end
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1111_BEEF, lat, e, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL hst_lat: got %0d want 3", lat); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'hBEEF_7F01) begin n_bad++; $display("FAIL hst_w20: got %h want beef7f01", rd); end
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL hmis_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'hBEEF_7F01) begin n_bad++; $display("FAIL hmis_rdata: got %h want beef7f01", rd); end
`else
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e, rd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL hdis_lat: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL hdis_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL hdis_rdata: got %h want 00000001", rd); end
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1111_BEEF, lat, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL hdis_st_err: got %b want 1", e); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h8000_7F01) begin n_bad++; $display("FAIL hdis_w20: got %h want 80007f01", rd); end
`endif
  endtask

  task automatic test_misaligned;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, e, rd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis_ld_lat: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_ld_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_bad++; $display("FAIL mis_ld_rdata: got %h want 1234ab78", rd); end
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hDEAD_BEEF, lat, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_st_err: got %b want 1", e); end
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, e, rd);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rsv_err: got %b want 1", e); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL mis_mem_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_bad++; $display("FAIL mis_mem: got %h want 1234ab78", rd); end
  endtask

  task automatic test_wrap;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_bad++; $display("FAIL wrap_ld: got %h want 1234ab78", rd); end
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_F030, 32'hCAFE_F00D, lat, e, rd);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, e, rd);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wrap_st: got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h10; wdata = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", rdata); end
    @(posedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    @(negedge clk) rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mid_post_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_bad++; $display("FAIL mid_mem: got %h want 1234ab78", rd); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] done_pat;
    logic [8:0] busy_pat;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      done_pat[i] = done;
      busy_pat[i] = busy;
    end
    req = 1'b0;
    n_cmp++; if (done_pat !== 9'b010010010) begin n_bad++; $display("FAIL b2b_done: got %b want 010010010", done_pat); end
    n_cmp++; if (busy_pat !== 9'b011011011) begin n_bad++; $display("FAIL b2b_busy: got %b want 011011011", busy_pat); end
    n_cmp++; if (rdata !== 32'h1234_AB78) begin n_bad++; $display("FAIL b2b_rdata: got %h want 1234ab78", rdata); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_misaligned;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  1  request valid, sampled only when busy=0.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port size  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
REQ-007 SHALL have port uns  input  1  1=zero-extend sub-word load, 0=sign-extend.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; access rejected.
REQ-013 SHALL have port rdata  output  32  load result, extended, valid with done for loads.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP; busy = (state != IDLE).
REQ-015 SHALL accept a request at rising edge E0 when state=IDLE and req=1, latching we, size, uns, addr, wdata; req while busy SHALL be ignored.
REQ-016 SHALL index memory with addr[ADDR_W+1:2]; higher address bits ignored (wrap-around).
REQ-017 SHALL flag misaligned (half with addr[0]=1, word with addr[1:0]!=0) and size=11 as error: IDLE->RESP at E0, done=1, err=1, no memory write, rdata unchanged.
REQ-018 Load: IDLE->READ at E0; READ->RESP at E1, latching word; done=1 in cycle after E1.
REQ-019 Load extraction: byte lane = addr[1:0], half lane = addr[1]; result extended per uns to 32 bits; word returned unchanged.
REQ-020 Word store: IDLE->WRITE at E0; memory written at E1; WRITE->RESP at E1.
REQ-021 Sub-word store (read-modify-write): IDLE->READ at E0; READ->WRITE at E1 latching old word; at E2 write old word with selected lane(s) replaced by wdata low bits, other lanes preserved; WRITE->RESP.
REQ-022 RESP SHALL last exactly one cycle then return to IDLE; done=1 only in RESP; err=0 on successful completion.
REQ-023 rdata SHALL hold its last load value until the next successful load completes; stores SHALL NOT alter rdata.
REQ-024 A request presented in the RESP cycle SHALL be ignored; earliest next acceptance is the edge after RESP.

Reset
REQ-025 rst_n=0 SHALL force state=IDLE, busy=0, done=0, err=0, rdata=0 immediately, independent of clk.
REQ-026 Reset mid-operation SHALL abort the access; a pending WRITE not yet performed SHALL NOT occur; memory contents SHALL NOT be cleared.
REQ-027 After rst_n deasserts, first acceptance SHALL be at the first rising edge with rst_n=1 and req=1.

Configuration
REQ-028 Macro DMC_HALFWORD_EN SHALL control halfword support.
REQ-029 With DMC_HALFWORD_EN defined, size=01 SHALL behave per REQ-017..REQ-021.
REQ-030 Without DMC_HALFWORD_EN, size=01 SHALL be rejected as error per REQ-017 regardless of alignment.

Verification
REQ-031 Word store 0x12345678 to addr 0x10, then word load 0x10 -> done 2 cycles after each accept; rdata=0x12345678, err=0.
REQ-032 After REQ-031, byte store 0xAB to 0x11, signed byte load 0x11 -> store takes 3 cycles to done; rdata=0xFFFFFFAB; word load 0x10 -> 0x1234AB78.
REQ-033 Unsigned byte load 0x11 -> rdata=0x000000AB; with DMC_HALFWORD_EN, signed half load 0x12 -> 0x00001234.
REQ-034 Word load at 0x13 -> done=1, err=1 in cycle after accept, rdata unchanged, memory unchanged.
REQ-035 Assert rst_n=0 during WRITE of byte store to 0x10 -> busy=0 immediately; word at 0x10 unchanged.
REQ-036 req held high continuously across a load -> exactly one access per IDLE visit; second request accepted at edge after RESP.
